// File: rtl/fft_rd_pkg.sv
// rtl/fft_rd_pkg.sv - shared constants and word-slot enum for fft_result_reader
// FFT_READER_POWER_EN appends NCH power words to every frame.
package fft_rd_pkg;

  localparam int NCH       = 7;
  localparam int DW        = 32;
  localparam int PWR_SHIFT = 16;
  localparam int NW_BASE   = 4 * NCH;
  localparam int NW_PWR    = 5 * NCH;

`ifdef FFT_READER_POWER_EN
  localparam int NW = NW_PWR;
`else
  localparam int NW = NW_BASE;
`endif

  typedef enum logic [1:0] {
    U_RE = 2'd0,
    U_IM = 2'd1,
    I_RE = 2'd2,
    I_IM = 2'd3
  } word_slot_e;

`ifdef FFT_READER_POWER_EN
  // Saturate when the bits above the DW-bit sign position are not a pure sign extension.
  function automatic logic [DW-1:0] power_word(input logic signed [DW-1:0] ure,
                                               input logic signed [DW-1:0] uim,
                                               input logic signed [DW-1:0] ire,
                                               input logic signed [DW-1:0] iim);
    logic signed [2*DW-1:0] p_re;
    logic signed [2*DW-1:0] p_im;
    logic signed [2*DW:0]   sum;
    logic signed [2*DW:0]   sh;
    p_re = ure * ire;
    p_im = uim * iim;
    sum  = (2*DW+1)'(p_re) + (2*DW+1)'(p_im);
    sh   = sum >>> PWR_SHIFT;
    if (!sh[2*DW] && (|sh[2*DW-1:DW-1]))
      power_word = {1'b0, {(DW-1){1'b1}}};
    else if (sh[2*DW] && !(&sh[2*DW-1:DW-1]))
      power_word = {1'b1, {(DW-1){1'b0}}};
    else
      power_word = sh[DW-1:0];
  endfunction
`endif

endpackage

// File: rtl/fft_result_reader_if.sv
// rtl/fft_result_reader_if.sv - outbound frame word stream with valid/ready/last
interface fft_result_reader_if;
  import fft_rd_pkg::*;

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/fft_rd_capture.sv
// rtl/fft_rd_capture.sv - one capture bank: done edge detect, bank register, full flag
module fft_rd_capture
  import fft_rd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [NCH*DW-1:0] re,
  input  logic [NCH*DW-1:0] im,
  input  logic              clr,
  output logic [NCH*DW-1:0] bank_re,
  output logic [NCH*DW-1:0] bank_im,
  output logic              full,
  output logic              ovr
);

  logic done_q;
  logic rise;

  assign rise = done & ~done_q;
  // A load coinciding with the copy-out is a fresh capture, not an overwrite.
  assign ovr  = rise & full & ~clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q  <= 1'b0;
      bank_re <= '0;
      bank_im <= '0;
      full    <= 1'b0;
    end else begin
      done_q <= done;
      if (rise) begin
        bank_re <= re;
        bank_im <= im;
        full    <= 1'b1;
      end else if (clr) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fft_result_reader.sv
// rtl/fft_result_reader.sv - double-buffered U/I FFT bin capture, serialized as one frame
// FFT_READER_POWER_EN adds per-channel power words after the bin words.
module fft_result_reader
  import fft_rd_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCH*DW-1:0]         u_re,
  input  logic [NCH*DW-1:0]         u_im,
  input  logic                      done_u,
  input  logic [NCH*DW-1:0]         i_re,
  input  logic [NCH*DW-1:0]         i_im,
  input  logic                      done_i,
  fft_result_reader_if.master       dst,
  output logic                      busy,
  output logic [7:0]                ovr_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]        state;
  logic [5:0]        w;
  logic [5:0]        w_nxt;
  logic              copy;
  logic              accept;
  logic [NCH*DW-1:0] bu_re, bu_im, bi_re, bi_im;
  logic [NCH*DW-1:0] sb_ure, sb_uim, sb_ire, sb_iim;
  logic              u_full, i_full, u_ovr, i_ovr;
  logic [NW_BASE*DW-1:0] frame;
  logic [DW-1:0]     next_word;
  logic [8:0]        ovr_sum;

  fft_rd_capture u_cap (
    .clk(clk), .reset(reset), .done(done_u), .re(u_re), .im(u_im), .clr(copy),
    .bank_re(bu_re), .bank_im(bu_im), .full(u_full), .ovr(u_ovr)
  );

  fft_rd_capture i_cap (
    .clk(clk), .reset(reset), .done(done_i), .re(i_re), .im(i_im), .clr(copy),
    .bank_re(bi_re), .bank_im(bi_im), .full(i_full), .ovr(i_ovr)
  );

  assign copy    = (state == ST_IDLE) && u_full && i_full;
  assign accept  = (state == ST_SEND) && dst.out_valid && dst.out_ready;
  assign w_nxt   = w + 6'd1;
  assign busy    = (state == ST_SEND);
  assign ovr_sum = {1'b0, ovr_cnt} + 9'(u_ovr) + 9'(i_ovr);

  always_comb begin
    frame = '0;
    for (int k = 0; k < NCH; k++) begin
      frame[(4*k + int'(U_RE))*DW +: DW] = sb_ure[k*DW +: DW];
      frame[(4*k + int'(U_IM))*DW +: DW] = sb_uim[k*DW +: DW];
      frame[(4*k + int'(I_RE))*DW +: DW] = sb_ire[k*DW +: DW];
      frame[(4*k + int'(I_IM))*DW +: DW] = sb_iim[k*DW +: DW];
    end
  end

`ifdef FFT_READER_POWER_EN
  logic [5:0] pidx;
  assign pidx = w_nxt - 6'(NW_BASE);
`endif

  // The word after the current one is prepared here so out_data stays a plain register.
  always_comb begin
    next_word = frame[int'(w_nxt)*DW +: DW];
`ifdef FFT_READER_POWER_EN
    if (w_nxt >= 6'(NW_BASE))
      next_word = power_word(sb_ure[int'(pidx)*DW +: DW], sb_uim[int'(pidx)*DW +: DW],
                             sb_ire[int'(pidx)*DW +: DW], sb_iim[int'(pidx)*DW +: DW]);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      w             <= 6'd0;
      dst.out_data  <= '0;
      dst.out_valid <= 1'b0;
      dst.out_last  <= 1'b0;
      sb_ure        <= '0;
      sb_uim        <= '0;
      sb_ire        <= '0;
      sb_iim        <= '0;
      ovr_cnt       <= 8'd0;
    end else begin
      ovr_cnt <= (ovr_sum > 9'd255) ? 8'hFF : ovr_sum[7:0];
      case (state)
        ST_IDLE: begin
          if (copy) begin
            sb_ure        <= bu_re;
            sb_uim        <= bu_im;
            sb_ire        <= bi_re;
            sb_iim        <= bi_im;
            w             <= 6'd0;
            dst.out_data  <= bu_re[DW-1:0];
            dst.out_valid <= 1'b1;
            dst.out_last  <= 1'b0;
            state         <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept) begin
            if (w == 6'(NW-1)) begin
              dst.out_valid <= 1'b0;
              dst.out_last  <= 1'b0;
              state         <= ST_IDLE;
            end else begin
              w            <= w_nxt;
              dst.out_data <= next_word;
              dst.out_last <= (w_nxt == 6'(NW-1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// tb/tb_fft_result_reader.sv - scoreboard bench for fft_result_reader
// Define FFT_READER_POWER_EN to also cover the power words.
module tb_fft_result_reader;
  import fft_rd_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH*DW-1:0] u_re, u_im, i_re, i_im;
  logic              done_u, done_i;
  logic              busy;
  logic [7:0]        ovr_cnt;
  logic [31:0]       ure [NCH];
  logic [31:0]       uim [NCH];
  logic [31:0]       ire [NCH];
  logic [31:0]       iim [NCH];
  exp_t              exp_q [$];
  int                checks = 0;
  int                failures = 0;
  int                ready_mode = 0;

  fft_result_reader_if bus ();

  fft_result_reader dut (
    .clk(clk), .reset(reset),
    .u_re(u_re), .u_im(u_im), .done_u(done_u),
    .i_re(i_re), .i_im(i_im), .done_i(done_i),
    .dst(bus), .busy(busy), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    u_re = '0; u_im = '0; i_re = '0; i_im = '0;
    for (int k = 0; k < NCH; k++) begin
      u_re[k*DW +: DW] = ure[k];
      u_im[k*DW +: DW] = uim[k];
      i_re[k*DW +: DW] = ire[k];
      i_im[k*DW +: DW] = iim[k];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_u(input logic [31:0] re_base, input logic [31:0] im_base);
    for (int k = 0; k < NCH; k++) begin
      ure[k] = re_base + 32'(k);
      uim[k] = im_base + 32'(k);
    end
  endtask

  task automatic set_i(input logic [31:0] re_base, input logic [31:0] im_base);
    for (int k = 0; k < NCH; k++) begin
      ire[k] = re_base + 32'(k);
      iim[k] = im_base + 32'(k);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input int n);
    exp_q.push_back({d, 1'(n == NW-1)});
  endtask

`ifdef FFT_READER_POWER_EN
  logic [31:0] p_exp [NCH];

  function automatic logic [31:0] pwr_model(input logic signed [31:0] a, input logic signed [31:0] b,
                                            input logic signed [31:0] c, input logic signed [31:0] d);
    longint p1, p2;
    logic signed [64:0] s;
    p1 = a * c;
    p2 = b * d;
    s  = 65'(p1) + 65'(p2);
    s  = s >>> 16;
    if (s > 65'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -65'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic model_power();
    for (int k = 0; k < NCH; k++) p_exp[k] = pwr_model(ure[k], uim[k], ire[k], iim[k]);
  endtask
`endif

  task automatic push_frame();
    int n;
    n = 0;
    for (int k = 0; k < NCH; k++) begin
      push_word(ure[k], n); n++;
      push_word(uim[k], n); n++;
      push_word(ire[k], n); n++;
      push_word(iim[k], n); n++;
    end
`ifdef FFT_READER_POWER_EN
    for (int k = 0; k < NCH; k++) begin
      push_word(p_exp[k], n); n++;
    end
`endif
  endtask

  task automatic std_frame(input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3);
    set_u(b0, b1);
    set_i(b2, b3);
`ifdef FFT_READER_POWER_EN
    model_power();
`endif
    push_frame();
  endtask

  task automatic wait_empty(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s timeout remaining=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : ready_driver
    int c;
    c = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      c++;
      bus.out_ready = (ready_mode == 0) || (c % 3 == 0);
    end
  end

  initial begin : monitor
    logic        stalled;
    logic [31:0] held_d;
    logic        held_l;
    exp_t        e;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", 64'(bus.out_valid), 64'd1);
          check("hold_data", 64'(bus.out_data), 64'(held_d));
          check("hold_last", 64'(bus.out_last), 64'(held_l));
        end
        if (bus.out_valid && bus.out_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_word actual=0x%0h expected=none", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("word_data", 64'(bus.out_data), 64'(e.data));
            check("word_last", 64'(bus.out_last), 64'(e.last));
          end
        end else if (bus.out_valid) begin
          stalled = 1'b1;
          held_d  = bus.out_data;
          held_l  = bus.out_last;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    reset  = 1'b1;
    done_u = 1'b0;
    done_i = 1'b0;
    set_u(0, 0);
    set_i(0, 0);
    tick(3);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_last", 64'(bus.out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovr", 64'(ovr_cnt), 64'd0);
    reset = 1'b0;
    tick(2);

    // 1: simultaneous done edges, sink always ready
    std_frame(32'h100, 32'h200, 32'h300, 32'h400);
    done_u = 1'b1;
    done_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    check("t1_latency", 64'(n), 64'd3);
    check("t1_busy", 64'(busy), 64'd1);
    wait_empty("t1_frame", 200);
    check("t1_end_valid", 64'(bus.out_valid), 64'd0);
    check("t1_end_busy", 64'(busy), 64'd0);
    done_u = 1'b0;
    done_i = 1'b0;
    tick(3);

    // 2: sink stalls two of every three cycles
    ready_mode = 1;
    std_frame(32'h100, 32'h200, 32'h300, 32'h400);
    done_u = 1'b1;
    done_i = 1'b1;
    wait_empty("t2_frame", 400);
    ready_mode = 0;
    done_u = 1'b0;
    done_i = 1'b0;
    tick(3);

    // 3: U overwritten before I arrives
    set_u(32'h100, 32'h200);
    done_u = 1'b1;
    tick(3);
    done_u = 1'b0;
    tick(7);
    set_u(32'h500, 32'h600);
    done_u = 1'b1;
    tick(2);
    check("t3_ovr", 64'(ovr_cnt), 64'd1);
    check("t3_idle", 64'(bus.out_valid), 64'd0);
    set_i(32'h700, 32'h800);
`ifdef FFT_READER_POWER_EN
    model_power();
`endif
    push_frame();
    done_i = 1'b1;
    wait_empty("t3_frame", 200);
    done_u = 1'b0;
    done_i = 1'b0;
    tick(3);

    // 4: second capture completes during SEND
    std_frame(32'h100, 32'h200, 32'h300, 32'h400);
    done_u = 1'b1;
    done_i = 1'b1;
    tick(3);
    done_u = 1'b0;
    done_i = 1'b0;
    tick(5);
    std_frame(32'h900, 32'hA00, 32'hB00, 32'hC00);
    done_u = 1'b1;
    done_i = 1'b1;
    tick(3);
    done_u = 1'b0;
    done_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.out_valid && bus.out_last) && n < 100);
    check("t4_first_last", 64'(bus.out_last), 64'd1);
    @(negedge clk);
    check("t4_gap", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("t4_resume", 64'(bus.out_valid), 64'd1);
    wait_empty("t4_frames", 200);
    check("t4_ovr", 64'(ovr_cnt), 64'd1);
    tick(3);

    // 5: async reset at word 10 aborts the frame
    std_frame(32'h100, 32'h200, 32'h300, 32'h400);
    done_u = 1'b1;
    done_i = 1'b1;
    for (int c = 0; c < 300 && exp_q.size() != NW-10; c++) @(posedge clk);
    check("t5_reach_w10", 64'(exp_q.size()), 64'(NW-10));
    #2;
    reset = 1'b1;
    #1;
    check("t5_valid", 64'(bus.out_valid), 64'd0);
    check("t5_last", 64'(bus.out_last), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_ovr", 64'(ovr_cnt), 64'd0);
    exp_q.delete();
    done_u = 1'b0;
    done_i = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(3);
    check("t5_post_valid", 64'(bus.out_valid), 64'd0);
    std_frame(32'hD00, 32'hE00, 32'hF00, 32'h1000);
    done_u = 1'b1;
    done_i = 1'b1;
    wait_empty("t5_frame", 200);
    done_u = 1'b0;
    done_i = 1'b0;
    tick(3);

    // 6: power vector on channel 0, all other channels zero
    set_u(0, 0);
    set_i(0, 0);
    ure[0] = 32'h10000;
    uim[0] = 32'h20000;
    ire[0] = 32'h30000;
    iim[0] = 32'h10000;
`ifdef FFT_READER_POWER_EN
    for (int k = 0; k < NCH; k++) p_exp[k] = 32'h0;
    p_exp[0] = 32'h50000;
`endif
    push_frame();
    done_u = 1'b1;
    done_i = 1'b1;
    wait_empty("t6_frame", 200);
    done_u = 1'b0;
    done_i = 1'b0;
    tick(5);
    check("final_idle", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
